serial_tx_ctrl_32_w: RTL

Frame transmitter for the FPGA serial link, the sending end of the word/CRC framing used by the link receiver. On a start request it reads n_word 16-bit words from a register bank through selector and hands them byte-wise, high byte first, to the UART transmitter. It feeds the same bytes to an external CRC-16 engine, then appends the CRC high and low bytes. Frame spacing (idle gap) is owned by the caller through start.

---
 rtl/serial_tx_ctrl_32_w.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/serial_tx_ctrl_32_w.sv
// Frame transmitter: reads n_word 16-bit words from a register bank and sends
// them byte-wise (high byte first) to a UART, then appends the CRC-16 of the data bytes.
module serial_tx_ctrl_32_w #(
  parameter logic [7:0] n_word = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic        tx_busy,
  input  logic [15:0] crc_16,
  input  logic        crc_busy,
  output logic [7:0]  selector,
  output logic [7:0]  byte_out,
  output logic        tx_start,
  output logic        crc_strb,
  output logic        crc_reset,
  output logic        busy,
  output logic        done,
  output logic [15:0] frames_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_CRC_CLR, S_LATCH, S_SEND_HI, S_ACK_HI, S_SEND_LO, S_ACK_LO,
    S_WAIT_SEL, S_CRC_WAIT, S_SEND_CH, S_ACK_CH, S_SEND_CL, S_ACK_CL
  } state_t;

  state_t      r_state;
  logic [7:0]  r_selector;
  logic [7:0]  r_byte_out;
  logic [15:0] r_word;
  logic [15:0] r_crc;
  logic [15:0] r_frames_cnt;
  logic        r_tx_start;
  logic        r_crc_strb;
  logic        r_crc_reset;
  logic        r_busy;
  logic        r_done;

  state_t      w_next_state;
  logic [7:0]  w_next_selector;
  logic [7:0]  w_next_byte;
  logic [15:0] w_next_word;
  logic [15:0] w_next_crc;
  logic [15:0] w_next_frames;
  logic        w_tx_start;
  logic        w_crc_strb;
  logic        w_crc_reset;
  logic        w_done;
  logic        w_last_word;

  assign w_last_word = (r_selector == (n_word - 8'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_selector   <= 8'd0;
      r_byte_out   <= 8'd0;
      r_word       <= 16'd0;
      r_crc        <= 16'd0;
      r_frames_cnt <= 16'd0;
      r_tx_start   <= 1'b0;
      r_crc_strb   <= 1'b0;
      r_crc_reset  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_selector   <= w_next_selector;
      r_byte_out   <= w_next_byte;
      r_word       <= w_next_word;
      r_crc        <= w_next_crc;
      r_frames_cnt <= w_next_frames;
      r_tx_start   <= w_tx_start;
      r_crc_strb   <= w_crc_strb;
      r_crc_reset  <= w_crc_reset;
      r_busy       <= (w_next_state != S_IDLE);
      r_done       <= w_done;
    end
  end

  // Strobes are decided here and registered, so each lands together with its byte_out.
  always_comb begin
    w_next_state    = r_state;
    w_next_selector = r_selector;
    w_next_byte     = r_byte_out;
    w_next_word     = r_word;
    w_next_crc      = r_crc;
    w_next_frames   = r_frames_cnt;
    w_tx_start      = 1'b0;
    w_crc_strb      = 1'b0;
    w_crc_reset     = 1'b0;
    w_done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_selector = 8'd0;
        if (start) w_next_state = S_CRC_CLR;
      end
      S_CRC_CLR: begin
        if (!crc_busy) begin
          w_crc_reset  = 1'b1;
          w_next_state = S_LATCH;
        end
      end
      S_LATCH: begin
        w_next_word  = data_in;
        w_next_state = S_SEND_HI;
      end
      S_SEND_HI: begin
        if (!tx_busy && !crc_busy) begin
          w_next_byte  = r_word[15:8];
          w_tx_start   = 1'b1;
          w_crc_strb   = 1'b1;
          w_next_state = S_ACK_HI;
        end
      end
      S_ACK_HI: begin
        if (tx_busy) w_next_state = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (!tx_busy && !crc_busy) begin
          w_next_byte  = r_word[7:0];
          w_tx_start   = 1'b1;
          w_crc_strb   = 1'b1;
          w_next_state = S_ACK_LO;
        end
      end
      S_ACK_LO: begin
        if (tx_busy) begin
          if (w_last_word) begin
            w_next_state = S_CRC_WAIT;
          end else begin
            w_next_selector = r_selector + 8'd1;
            w_next_state    = S_WAIT_SEL;
          end
        end
      end
      S_WAIT_SEL: w_next_state = S_LATCH;
      S_CRC_WAIT: begin
        if (!crc_busy && !tx_busy) begin
          w_next_crc   = crc_16;
          w_next_state = S_SEND_CH;
        end
      end
      S_SEND_CH: begin
        if (!tx_busy) begin
          w_next_byte  = r_crc[15:8];
          w_tx_start   = 1'b1;
          w_next_state = S_ACK_CH;
        end
      end
      S_ACK_CH: begin
        if (tx_busy) w_next_state = S_SEND_CL;
      end
      S_SEND_CL: begin
        if (!tx_busy) begin
          w_next_byte  = r_crc[7:0];
          w_tx_start   = 1'b1;
          w_next_state = S_ACK_CL;
        end
      end
      S_ACK_CL: begin
        if (tx_busy) begin
          w_done        = 1'b1;
          w_next_frames = r_frames_cnt + 16'd1;
          w_next_state  = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign selector   = r_selector;
  assign byte_out   = r_byte_out;
  assign tx_start   = r_tx_start;
  assign crc_strb   = r_crc_strb;
  assign crc_reset  = r_crc_reset;
  assign busy       = r_busy;
  assign done       = r_done;
  assign frames_cnt = r_frames_cnt;

endmodule
